// File: rtl/mel_log_compress.sv
// Log2 compression of mel filterbank energies into the DCT input buffer.
// Sequences frames: last code written -> DCT start pulse -> hold off until DCT done.
module mel_log_compress #(
  parameter int NUM_FILTERS  = 40,
  parameter int ENERGY_WIDTH = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FRAC_BITS    = 2,
  parameter int NF_LOG2      = $clog2(NUM_FILTERS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    energy_valid_i,
  output logic                    energy_ready_o,
  input  logic [ENERGY_WIDTH-1:0] energy_i,
  input  logic [NF_LOG2-1:0]      energy_ptr_i,
  output logic                    out_valid_o,
  output logic [NF_LOG2-1:0]      frame_ptr_o,
  output logic [OUTPUT_WIDTH-1:0] power_o,
  output logic                    start_o,
  input  logic                    dct_done_i,
  output logic                    ptr_err_o
);
  localparam int MSB_W    = $clog2(ENERGY_WIDTH);
  localparam int CODE_W   = MSB_W + FRAC_BITS;
  localparam int CODE_MAX = 2**(OUTPUT_WIDTH-1) - 1;
  localparam logic [NF_LOG2-1:0] LAST_IDX = NF_LOG2'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {COLLECT, FLUSH, START, WAIT_DCT} state_t;

  state_t             state_q, state_d;
  logic [NF_LOG2-1:0] count_q, count_d;
  logic               accept, last_accept;

  logic                    in_valid_q, in_last_q;
  logic [ENERGY_WIDTH-1:0] in_x_q;
  logic [NF_LOG2-1:0]      in_ptr_q;

  logic                    s1_valid_q, s1_last_q;
  logic [ENERGY_WIDTH-1:0] s1_x_q;
  logic [NF_LOG2-1:0]      s1_ptr_q;
  logic [MSB_W-1:0]        s1_msb_q;

  logic                    out_valid_q, out_last_q, ptr_err_q;
  logic [NF_LOG2-1:0]      frame_ptr_q;
  logic [OUTPUT_WIDTH-1:0] power_q;

  logic [MSB_W-1:0]        msb_d;
  logic [FRAC_BITS-1:0]    frac_d;
  logic [CODE_W-1:0]       code_d;
  logic [OUTPUT_WIDTH-1:0] power_d;

  assign energy_ready_o = (state_q == COLLECT);
  assign accept         = energy_valid_i && energy_ready_o;
  assign last_accept    = accept && (count_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          count_d = count_q + NF_LOG2'(1);
          if (last_accept) state_d = FLUSH;
        end
      end
      // The last sample carries a tag so earlier in-flight codes do not trigger START.
      FLUSH:    if (out_valid_q && out_last_q) state_d = START;
      START:    state_d = WAIT_DCT;
      WAIT_DCT: begin
        if (dct_done_i) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default:  state_d = COLLECT;
    endcase
  end

  // Priority encoder: highest set bit wins.
  always_comb begin
    msb_d = '0;
    for (int i = 0; i < ENERGY_WIDTH; i++) begin
      if (in_x_q[i]) msb_d = MSB_W'(i);
    end
  end

  always_comb begin
    frac_d  = FRAC_BITS'({s1_x_q, {FRAC_BITS{1'b0}}} >> s1_msb_q);
    code_d  = {s1_msb_q, frac_d};
    power_d = '0;
    if (s1_x_q != '0) begin
      if (32'(code_d) > 32'(CODE_MAX)) power_d = OUTPUT_WIDTH'(CODE_MAX);
      else                             power_d = OUTPUT_WIDTH'(code_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q  <= 1'b0;
      in_last_q   <= 1'b0;
      in_x_q      <= '0;
      in_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_ptr_q    <= '0;
      s1_msb_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ptr_q <= '0;
      power_q     <= '0;
      ptr_err_q   <= 1'b0;
    end else begin
      in_valid_q  <= accept;
      in_last_q   <= last_accept;
      s1_valid_q  <= in_valid_q;
      s1_last_q   <= in_last_q;
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_last_q;
      if (accept) begin
        in_x_q   <= energy_i;
        in_ptr_q <= energy_ptr_i;
        if (energy_ptr_i != count_q) ptr_err_q <= 1'b1;
      end
      if (in_valid_q) begin
        s1_x_q   <= in_x_q;
        s1_ptr_q <= in_ptr_q;
        s1_msb_q <= msb_d;
      end
      if (s1_valid_q) begin
        power_q     <= power_d;
        frame_ptr_q <= s1_ptr_q;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign frame_ptr_o = frame_ptr_q;
  assign power_o     = power_q;
  assign start_o     = (state_q == START);
  assign ptr_err_o   = ptr_err_q;

endmodule

// File: tb/tb_mel_log_compress.sv
// Randomized bench for mel_log_compress: a cycle-level reference model predicts
// codes, handshake and frame sequencing; scenario tasks add targeted checks.
module tb_mel_log_compress;
  localparam int NF  = 40;
  localparam int EW  = 32;
  localparam int OW  = 8;
  localparam int NFL = $clog2(NF);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           energy_valid_i = 1'b0;
  logic           energy_ready_o;
  logic [EW-1:0]  energy_i = '0;
  logic [NFL-1:0] energy_ptr_i = '0;
  logic           out_valid_o;
  logic [NFL-1:0] frame_ptr_o;
  logic [OW-1:0]  power_o;
  logic           start_o;
  logic           dct_done_i = 1'b0;
  logic           ptr_err_o;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_out = 0;

  typedef struct {int due; int ptr; int code;} exp_t;
  exp_t exp_q[$];
  int   m_edge = 0;
  int   m_cnt = 0;
  int   m_last = 0;
  bit   m_err = 1'b0;

  mel_log_compress #(
    .NUM_FILTERS(NF), .ENERGY_WIDTH(EW), .OUTPUT_WIDTH(OW), .FRAC_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .energy_valid_i(energy_valid_i), .energy_ready_o(energy_ready_o),
    .energy_i(energy_i), .energy_ptr_i(energy_ptr_i),
    .out_valid_o(out_valid_o), .frame_ptr_o(frame_ptr_o), .power_o(power_o),
    .start_o(start_o), .dct_done_i(dct_done_i), .ptr_err_o(ptr_err_o)
  );

  always #5 clk = ~clk;

  // log2 code straight from the arithmetic definition
  function automatic int ref_code(input logic [31:0] x);
    longint unsigned v;
    int m;
    int code;
    if (x == 0) return 0;
    v = 64'(x);
    m = 0;
    while ((v >> (m + 1)) != 0) m++;
    code = m * 4 + int'(((v << 2) >> m) & 64'd3);
    if (code > 127) code = 127;
    return code;
  endfunction

  function automatic logic [31:0] rand_energy();
    if ($urandom_range(0, 7) == 0) return 32'd0;
    return $urandom >> $urandom_range(0, 31);
  endfunction

  task automatic model_loop();
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_cnt = 0;
        m_err = 1'b0;
      end else begin
        m_edge++;
        if (m_cnt == NF) begin
          if (dct_done_i && m_edge >= m_last + 5) m_cnt = 0;
        end else if (energy_valid_i) begin
          e.due  = m_edge + 2;
          e.ptr  = int'(energy_ptr_i);
          e.code = ref_code(energy_i);
          exp_q.push_back(e);
          if (int'(energy_ptr_i) != m_cnt) m_err = 1'b1;
          m_cnt++;
          if (m_cnt == NF) m_last = m_edge;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    bit ev;
    forever begin
      @(negedge clk);
      ev = (exp_q.size() > 0) && (exp_q[0].due == m_edge);
      n_vec++;
      if (out_valid_o !== ev) begin
        n_err++; $display("FAIL out_valid at edge %0d: got %b want %b", m_edge, out_valid_o, ev);
      end
      if (ev) begin
        e = exp_q.pop_front();
        n_vec++;
        if (power_o !== OW'(e.code)) begin
          n_err++; $display("FAIL power_o ptr %0d: got %0d want %0d", e.ptr, power_o, e.code);
        end
        n_vec++;
        if (frame_ptr_o !== NFL'(e.ptr)) begin
          n_err++; $display("FAIL frame_ptr_o: got %0d want %0d", frame_ptr_o, e.ptr);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].due < m_edge) e = exp_q.pop_front();
      n_vec++;
      if (energy_ready_o !== (m_cnt < NF)) begin
        n_err++; $display("FAIL energy_ready_o at edge %0d: got %b want %b", m_edge, energy_ready_o, m_cnt < NF);
      end
      n_vec++;
      if (start_o !== (m_cnt == NF && m_edge == m_last + 3)) begin
        n_err++; $display("FAIL start_o at edge %0d: got %b", m_edge, start_o);
      end
      n_vec++;
      if (ptr_err_o !== m_err) begin
        n_err++; $display("FAIL ptr_err_o at edge %0d: got %b want %b", m_edge, ptr_err_o, m_err);
      end
      if (start_o === 1'b1) n_start++;
      if (out_valid_o === 1'b1) n_out++;
    end
  endtask

  // Present a sample from a negedge until the DUT takes it; returns at the next negedge.
  task automatic send(input logic [31:0] x, input int ptr);
    int k;
    energy_valid_i = 1'b1;
    energy_i       = x;
    energy_ptr_i   = NFL'(ptr);
    k = 0;
    while (energy_ready_o !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_vec++; n_err++; $display("FAIL send timeout ptr %0d: ready stuck at %b", ptr, energy_ready_o);
    end
    @(negedge clk);
    energy_valid_i = 1'b0;
  endtask

  task automatic wait_start(input int s0);
    int k;
    k = 0;
    while (n_start == s0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_vec++; n_err++; $display("FAIL wait_start: start_o count %0d want %0d", n_start - s0, 1);
    end
  endtask

  task automatic done_pulse();
    @(negedge clk);
    dct_done_i = 1'b1;
    @(negedge clk);
    dct_done_i = 1'b0;
    n_vec++;
    if (energy_ready_o !== 1'b1) begin
      n_err++; $display("FAIL ready_after_done: got %b want 1", energy_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset out_valid_o: got %b want 0", out_valid_o); end
    n_vec++; if (frame_ptr_o !== '0) begin n_err++; $display("FAIL reset frame_ptr_o: got %0d want 0", frame_ptr_o); end
    n_vec++; if (power_o !== '0) begin n_err++; $display("FAIL reset power_o: got %0d want 0", power_o); end
    n_vec++; if (start_o !== 1'b0) begin n_err++; $display("FAIL reset start_o: got %b want 0", start_o); end
    n_vec++; if (ptr_err_o !== 1'b0) begin n_err++; $display("FAIL reset ptr_err_o: got %b want 0", ptr_err_o); end
    n_vec++; if (energy_ready_o !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b want 1", energy_ready_o); end
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_values();
    logic [31:0] vals [7];
    int          codes [7];
    int          s0;
    vals  = '{32'd0, 32'd1, 32'd3, 32'd6, 32'd1000, 32'h8000_0000, 32'hFFFF_FFFF};
    codes = '{0, 0, 6, 10, 39, 124, 127};
    s0 = n_start;
    for (int j = 0; j < 10; j++) begin
      if (j >= 3) begin
        n_vec++;
        if (out_valid_o !== 1'b1 || power_o !== OW'(codes[j-3]) || frame_ptr_o !== NFL'(j-3)) begin
          n_err++;
          $display("FAIL values idx %0d: got v=%b code=%0d ptr=%0d want v=1 code=%0d ptr=%0d",
                   j - 3, out_valid_o, power_o, frame_ptr_o, codes[j-3], j - 3);
        end
      end
      if (j < 7) begin
        energy_valid_i = 1'b1;
        energy_i       = vals[j];
        energy_ptr_i   = NFL'(j);
      end else begin
        energy_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 7; i < NF; i++) send(rand_energy(), i);
    wait_start(s0);
    repeat (3) @(negedge clk);
    done_pulse();
  endtask

  task automatic test_full_frame();
    int s0, o0;
    s0 = n_start;
    o0 = n_out;
    for (int i = 0; i < NF; i++) send(rand_energy(), i);
    n_vec++;
    if (energy_ready_o !== 1'b0) begin n_err++; $display("FAIL full ready_after_last: got %b want 0", energy_ready_o); end
    wait_start(s0);
    repeat (5) @(negedge clk);
    n_vec++; if (n_start - s0 !== 1) begin n_err++; $display("FAIL full start_count: got %0d want 1", n_start - s0); end
    n_vec++; if (n_out - o0 !== NF) begin n_err++; $display("FAIL full out_count: got %0d want %0d", n_out - o0, NF); end
    n_vec++; if (ptr_err_o !== 1'b0) begin n_err++; $display("FAIL full ptr_err: got %b want 0", ptr_err_o); end
  endtask

  task automatic test_holdoff();
    int o0;
    o0 = n_out;
    energy_valid_i = 1'b1;
    energy_i       = rand_energy();
    energy_ptr_i   = '0;
    repeat (100) @(negedge clk);
    n_vec++; if (energy_ready_o !== 1'b0) begin n_err++; $display("FAIL holdoff ready: got %b want 0", energy_ready_o); end
    energy_valid_i = 1'b0;
    n_vec++; if (n_out !== o0) begin n_err++; $display("FAIL holdoff out_count: got %0d want 0", n_out - o0); end
    done_pulse();
  endtask

  task automatic test_gapped();
    int s0, o0;
    s0 = n_start;
    o0 = n_out;
    for (int i = 0; i < NF; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(rand_energy(), i);
    end
    wait_start(s0);
    repeat (5) @(negedge clk);
    n_vec++; if (n_start - s0 !== 1) begin n_err++; $display("FAIL gapped start_count: got %0d want 1", n_start - s0); end
    n_vec++; if (n_out - o0 !== NF) begin n_err++; $display("FAIL gapped out_count: got %0d want %0d", n_out - o0, NF); end
    n_vec++; if (ptr_err_o !== 1'b0) begin n_err++; $display("FAIL gapped ptr_err: got %b want 0", ptr_err_o); end
    done_pulse();
  endtask

  task automatic test_order_err();
    int s0;
    s0 = n_start;
    for (int i = 0; i < NF; i++) begin
      send(rand_energy(), (i == 2) ? 5 : i);
      if (i == 1) begin
        n_vec++; if (ptr_err_o !== 1'b0) begin n_err++; $display("FAIL order early ptr_err: got %b want 0", ptr_err_o); end
      end
      if (i == 2) begin
        n_vec++; if (ptr_err_o !== 1'b1) begin n_err++; $display("FAIL order ptr_err set: got %b want 1", ptr_err_o); end
      end
    end
    wait_start(s0);
    repeat (3) @(negedge clk);
    n_vec++; if (ptr_err_o !== 1'b1) begin n_err++; $display("FAIL order ptr_err sticky: got %b want 1", ptr_err_o); end
    done_pulse();
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int i = 0; i < 20; i++) send(rand_energy(), i);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid_o !== 1'b0 || frame_ptr_o !== '0 || power_o !== '0 || start_o !== 1'b0 || ptr_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got v=%b ptr=%0d code=%0d start=%b err=%b want all 0",
               out_valid_o, frame_ptr_o, power_o, start_o, ptr_err_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    s0 = n_start;
    for (int i = 0; i < NF; i++) begin
      send(rand_energy(), i);
      if (i == NF - 2) begin
        n_vec++; if (n_start !== s0) begin n_err++; $display("FAIL reset_mid early start: got %0d want 0", n_start - s0); end
      end
    end
    wait_start(s0);
    repeat (5) @(negedge clk);
    n_vec++; if (n_start - s0 !== 1) begin n_err++; $display("FAIL reset_mid start_count: got %0d want 1", n_start - s0); end
    n_vec++; if (ptr_err_o !== 1'b0) begin n_err++; $display("FAIL reset_mid ptr_err: got %b want 0", ptr_err_o); end
    done_pulse();
  endtask

  initial begin
    fork
      model_loop();
      monitor_loop();
    join_none
    test_reset();
    test_values();
    test_full_frame();
    test_holdoff();
    test_gapped();
    test_order_err();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
